// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state codes, oversampling
// ratio and the bit-decision helpers used by the receive path.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int MAX_DATA_BITS = 9;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bad(input logic [1:0] mode,
                                        input logic [MAX_DATA_BITS-1:0] word,
                                        input logic pbit);
        logic ones_odd;
        logic bad;
        ones_odd = ^{word, pbit};
        case (mode)
            PAR_ODD:  bad = ~ones_odd;
            PAR_EVEN: bad = ones_odd;
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; push while full is allowed
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic             valid
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             push_ok_s, pop_ok_s;
    logic [WIDTH-1:0] head_r, head_next_s;
    logic             valid_r;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = head_r;
    assign valid = valid_r;

    // Next pointer/count and the word that becomes the head after this edge.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        rd_next_s = pop_ok_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array; contents beyond the count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            valid_r  <= (count_next_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit decisions, per-word
// parity/framing status and a receive FIFO on a valid/ready interface.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WORD_W = DATA_BITS + 2;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [1:0]       PAR_MODE  = 2'(PARITY);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_fifo: illegal parameter set");
    end

    logic                 sync1_r, sync2_r, rx_s;
    rx_state_t            state_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [3:0]           tick_idx_r, bit_cnt_r;
    logic                 s7_r, s8_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_err_r, frm_err_r, busy_r, overrun_r;
    logic                 tick_s, decide_s, end_s, bit_val_s, push_s, pop_s;
    logic                 full_s, empty_s;
    logic [WORD_W-1:0]    push_word_s, head_s;

    assign rx_s        = sync2_r;
    assign tick_s      = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST);
    assign decide_s    = tick_s && (tick_idx_r == 4'd9);
    assign end_s       = tick_s && (tick_idx_r == 4'd15);
    assign bit_val_s   = maj3(s7_r, s8_r, rx_s);
    assign push_s      = (state_r == ST_STOP) && decide_s && (bit_cnt_r == LAST_STOP);
    assign push_word_s = {frm_err_r | ~bit_val_s, par_err_r, shift_r};
    assign pop_s       = ready & ~empty_s;

    // Two-flop synchronizer, idle-high after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Oversample divider and tick index; held at zero while idle so they start aligned to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            tick_idx_r <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            tick_idx_r <= 4'd0;
        end else if (tick_s) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            tick_idx_r <= tick_idx_r + 4'd1;
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_W'(1);
        end
    end

    // First two of the three mid-bit samples; the third is the live synchronized value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s7_r <= 1'b1;
            s8_r <= 1'b1;
        end else begin
            if (tick_s && (tick_idx_r == 4'd7)) begin
                s7_r <= rx_s;
            end
            if (tick_s && (tick_idx_r == 4'd8)) begin
                s8_r <= rx_s;
            end
        end
    end

    // Frame sequencing; the last stop bit finishes at its decision tick to catch a back-to-back start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_r   <= ST_START;
                        bit_cnt_r <= 4'd0;
                        par_err_r <= 1'b0;
                        frm_err_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide_s && bit_val_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (end_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shift_r <= {bit_val_s, shift_r[DATA_BITS-1:1]};
                    end
                    if (end_s) begin
                        if (bit_cnt_r == LAST_DATA) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_s) begin
                        par_err_r <= parity_bad(PAR_MODE, MAX_DATA_BITS'(shift_r), bit_val_s);
                    end
                    if (end_s) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide_s) begin
                        if (bit_cnt_r == LAST_STOP) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            frm_err_r <= frm_err_r | ~bit_val_s;
                        end
                    end else if (end_s) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Overrun flags a completed frame that found the FIFO full with no pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= push_s & full_s & ~pop_s;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s),
        .valid     (valid)
    );

    assign data       = head_s[DATA_BITS-1:0];
    assign parity_err = head_s[DATA_BITS];
    assign frame_err  = head_s[DATA_BITS+1];
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and a 7E2 instance driven by
// directed and random frames, checked against a queue-based reference model.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rx_a, rx_b, ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       perr_a, ferr_a, valid_a, ovr_a, busy_a;
    logic       perr_b, ferr_b, valid_b, ovr_b, busy_b;

    uart_rx_fifo #(.CLK_FREQ(3200000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .parity_err(perr_a),
        .frame_err(ferr_a), .valid(valid_a), .ready(ready_a), .overrun(ovr_a), .busy(busy_a));

    uart_rx_fifo #(.CLK_FREQ(3200000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .parity_err(perr_b),
        .frame_err(ferr_b), .valid(valid_b), .ready(ready_b), .overrun(ovr_b), .busy(busy_b));

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] pop_a[$], pop_b[$], exp_a[$], exp_b[$], mq_a[$], mq_b[$];
    int ovr_cnt_a = 0, ovr_cnt_b = 0;
    int exp_ovr_a = 0, exp_ovr_b = 0;
    int chk_a = 0, chk_b = 0;

    // Records every accepted word and overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_a && ready_a) pop_a.push_back({ferr_a, perr_a, 1'b0, data_a});
        if (valid_b && ready_b) pop_b.push_back({ferr_b, perr_b, 2'b00, data_b});
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Model of where a completed frame goes: straight out, into the FIFO, or dropped.
    task automatic model_push(input int inst, input logic [10:0] w);
        if (inst == 0) begin
            if (ready_a) exp_a.push_back(w);
            else if (mq_a.size() < 4) mq_a.push_back(w);
            else exp_ovr_a++;
        end else begin
            if (ready_b) exp_b.push_back(w);
            else if (mq_b.size() < 4) mq_b.push_back(w);
            else exp_ovr_b++;
        end
    endtask

    task automatic release_ready(input int inst);
        if (inst == 0) begin
            while (mq_a.size() > 0) exp_a.push_back(mq_a.pop_front());
            ready_a = 1'b1;
        end else begin
            while (mq_b.size() > 0) exp_b.push_back(mq_b.pop_front());
            ready_b = 1'b1;
        end
    endtask

    // Instance 0 is 8N1, instance 1 is 7 data bits, even parity, 2 stop bits.
    task automatic send(input int inst, input logic [8:0] d, input logic par_flip,
                        input logic stop_zero, input int glitch_bit);
        int nb, pm, ns, nf, req;
        logic [8:0]  dm;
        logic [15:0] fr;
        logic        pbit, perr;
        nb = (inst == 0) ? 8 : 7;
        pm = (inst == 0) ? 0 : 2;
        ns = (inst == 0) ? 1 : 2;
        dm = d & 9'((1 << nb) - 1);
        fr = 16'hFFFF;
        pbit = 1'b0;
        perr = 1'b0;
        fr[0] = 1'b0;
        nf = 1;
        for (int i = 0; i < nb; i++) begin
            fr[nf] = dm[i];
            nf = nf + 1;
        end
        if (pm != 0) begin
            pbit = (pm == 2) ? ($countones(dm) % 2 == 1) : ($countones(dm) % 2 == 0);
            pbit = pbit ^ par_flip;
            fr[nf] = pbit;
            nf = nf + 1;
            req  = (pm == 1) ? 1 : 0;
            perr = ((($countones(dm) + int'(pbit)) % 2) != req);
        end
        for (int s = 0; s < ns; s++) begin
            fr[nf] = (s == 0 && stop_zero) ? 1'b0 : 1'b1;
            nf = nf + 1;
        end
        for (int b = 0; b < nf; b++) begin
            set_rx(inst, fr[b]);
            if (b == glitch_bit) begin
                cyc(18);
                set_rx(inst, ~fr[b]);
                cyc(1);
                set_rx(inst, fr[b]);
                cyc(13);
            end else begin
                cyc(32);
            end
        end
        set_rx(inst, 1'b1);
        model_push(inst, {stop_zero, perr, dm});
    endtask

    task automatic check_pops(input int inst, input string tag);
        if (inst == 0) begin
            chk({tag, " count"}, pop_a.size(), exp_a.size());
            for (int i = chk_a; i < exp_a.size() && i < pop_a.size(); i++)
                chk({tag, " word"}, pop_a[i], exp_a[i]);
            chk_a = exp_a.size();
            chk({tag, " overrun"}, ovr_cnt_a, exp_ovr_a);
        end else begin
            chk({tag, " count"}, pop_b.size(), exp_b.size());
            for (int i = chk_b; i < exp_b.size() && i < pop_b.size(); i++)
                chk({tag, " word"}, pop_b[i], exp_b[i]);
            chk_b = exp_b.size();
            chk({tag, " overrun"}, ovr_cnt_b, exp_ovr_b);
        end
    endtask

    initial begin
        logic [10:0] head_w;
        int inst;
        reset = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        cyc(5);
        chk("rst data", data_a, 0);
        chk("rst perr", perr_a, 0);
        chk("rst ferr", ferr_a, 0);
        chk("rst valid", valid_a, 0);
        chk("rst overrun", ovr_a, 0);
        chk("rst busy", busy_a, 0);
        chk("rst valid b", valid_b, 0);
        reset = 1'b1;
        cyc(5);

        ready_a = 1'b1; ready_b = 1'b1;
        send(0, 9'h0A5, 1'b0, 1'b0, -1);
        send(0, 9'h03C, 1'b0, 1'b0, -1);
        cyc(64);
        check_pops(0, "b2b");

        send(1, 9'h041, 1'b0, 1'b0, -1); cyc(64);
        send(1, 9'h041, 1'b1, 1'b0, -1); cyc(64);
        check_pops(1, "parity");

        send(0, 9'h055, 1'b0, 1'b1, -1); cyc(64);
        chk("stop0 busy", busy_a, 0);
        send(0, 9'h055, 1'b0, 1'b0, -1); cyc(64);
        check_pops(0, "frame");
        send(1, 9'h055, 1'b0, 1'b1, -1); cyc(64);
        check_pops(1, "frame b");

        set_rx(0, 1'b0); cyc(6);
        chk("glitch busy", busy_a, 1);
        cyc(6); set_rx(0, 1'b1); cyc(40);
        chk("glitch idle", busy_a, 0);
        check_pops(0, "glitch start");
        send(0, 9'h05A, 1'b0, 1'b0, 2); cyc(64);
        check_pops(0, "glitch data");

        ready_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(0, 9'(k), 1'b0, 1'b0, -1);
            cyc(8);
        end
        cyc(10);
        chk("full valid", valid_a, 1);
        head_w = mq_a[0];
        chk("full head", data_a, head_w[7:0]);
        check_pops(0, "fill");
        release_ready(0);
        cyc(10);
        check_pops(0, "drain");
        chk("drain valid", valid_a, 0);

        ready_b = 1'b0;
        send(1, 9'h033, 1'b0, 1'b0, -1); cyc(20);
        chk("pre-rst valid", valid_b, 1);
        set_rx(1, 1'b0); cyc(32);
        set_rx(1, 1'b1); cyc(32);
        set_rx(1, 1'b1); cyc(10);
        chk("mid busy", busy_b, 1);
        reset = 1'b0;
        mq_a.delete(); mq_b.delete();
        cyc(3);
        chk("mid rst data", data_b, 0);
        chk("mid rst perr", perr_b, 0);
        chk("mid rst ferr", ferr_b, 0);
        chk("mid rst valid", valid_b, 0);
        chk("mid rst overrun", ovr_b, 0);
        chk("mid rst busy", busy_b, 0);
        reset = 1'b1;
        cyc(64);
        release_ready(1);
        send(1, 9'h02A, 1'b0, 1'b0, -1); cyc(64);
        check_pops(1, "post rst");
        for (int i = 0; i < pop_b.size(); i++)
            chk("no 0x0F", (pop_b[i][6:0] == 7'h0F), 0);

        for (int r = 0; r < 8; r++) begin
            inst = r % 2;
            send(inst, 9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : -1);
            cyc(64);
        end
        check_pops(0, "random a");
        check_pops(1, "random b");
        chk("end busy a", busy_a, 0);
        chk("end busy b", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
